// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the handshaking multicycle MIPS-subset controller.
// Mux-select values match the existing datapath wiring.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE_R  = 4'd6,
    S_EXE_I  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JREG   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD, C_STORE, C_RTYPE, C_ITYPE, C_BRANCH, C_JUMP, C_JREG, C_ILLEGAL
  } inst_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  localparam logic [1:0] PCS_PC4   = 2'd0;
  localparam logic [1:0] PCS_BR    = 2'd1;
  localparam logic [1:0] PCS_JMP   = 2'd2;
  localparam logic [1:0] PCS_REG   = 2'd3;
  localparam logic [1:0] ASA_PC    = 2'd0;
  localparam logic [1:0] ASA_RS    = 2'd1;
  localparam logic [1:0] ASA_SHAMT = 2'd2;
  localparam logic [1:0] ASB_RT    = 2'd0;
  localparam logic [1:0] ASB_4     = 2'd1;
  localparam logic [1:0] ASB_IMM   = 2'd2;
  localparam logic [1:0] ASB_BR    = 2'd3;
  localparam logic [1:0] GPR_RD    = 2'd0;
  localparam logic [1:0] GPR_RT    = 2'd1;
  localparam logic [1:0] GPR_RA    = 2'd2;
  localparam logic [1:0] WD_ALU    = 2'd0;
  localparam logic [1:0] WD_MEM    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decoder: Op/Funct to instruction class, ALU op and
// sign-extension select, plus the few flags the FSM needs to tell variants apart.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output inst_cls_t  cls,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       is_shift,
  output logic       is_link,
  output logic       is_bne
);

  always_comb begin
    cls      = C_ILLEGAL;
    alu_op   = ALU_ADD;
    ext_op   = 1'b0;
    is_shift = 1'b0;
    is_link  = 1'b0;
    is_bne   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: begin cls = C_RTYPE; alu_op = ALU_ADD; end
          F_SUB, F_SUBU: begin cls = C_RTYPE; alu_op = ALU_SUB; end
          F_AND:         begin cls = C_RTYPE; alu_op = ALU_AND; end
          F_OR:          begin cls = C_RTYPE; alu_op = ALU_OR;  end
          F_SLT:         begin cls = C_RTYPE; alu_op = ALU_SLT; end
          F_SLL:         begin cls = C_RTYPE; alu_op = ALU_SLL; is_shift = 1'b1; end
          F_SRL:         begin cls = C_RTYPE; alu_op = ALU_SRL; is_shift = 1'b1; end
          F_JR:          cls = C_JREG;
          F_JALR:        begin cls = C_JREG; is_link = 1'b1; end
          default:       cls = C_ILLEGAL;
        endcase
      end
      OP_LW:   begin cls = C_LOAD;   ext_op = 1'b1; end
      OP_SW:   begin cls = C_STORE;  ext_op = 1'b1; end
      OP_ADDI: begin cls = C_ITYPE;  ext_op = 1'b1; alu_op = ALU_ADD; end
      OP_ORI:  begin cls = C_ITYPE;  alu_op = ALU_OR;  end
      OP_LUI:  begin cls = C_ITYPE;  alu_op = ALU_LUI; end
      OP_BEQ:  begin cls = C_BRANCH; alu_op = ALU_SUB; end
      OP_BNE:  begin cls = C_BRANCH; alu_op = ALU_SUB; is_bne = 1'b1; end
      OP_J:    cls = C_JUMP;
      OP_JAL:  begin cls = C_JUMP; is_link = 1'b1; end
      default: cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS-subset controller with a memory request/ready handshake,
// a per-access timeout watchdog and a sticky illegal-instruction/timeout trap.
module mc_ctrl_hs
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               EXTOp,
  output logic               IorD,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic               fault,
  output logic [3:0]         state_dbg
);

  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

  state_t         state, state_nx;
  logic [CW-1:0]  wait_cnt;
  logic           fault_q;
  logic [1:0]     gpr_sel_q;
  logic           in_mem, timeout;
  logic [3:0]     alu_sel;

  inst_cls_t      dec_cls;
  logic [3:0]     dec_alu;
  logic           dec_ext, dec_shift, dec_link, dec_bne;

  mc_ctrl_dec u_dec (
    .op       (Op),
    .funct    (Funct),
    .cls      (dec_cls),
    .alu_op   (dec_alu),
    .ext_op   (dec_ext),
    .is_shift (dec_shift),
    .is_link  (dec_link),
    .is_bne   (dec_bne)
  );

  // Handshake: mem_req stays high for the whole access; the access completes in
  // the cycle mem_ready is sampled high with mem_req high. mem_ready alone is ignored.
  assign in_mem  = is_mem_state(state);
  assign timeout = (TIMEOUT > 0) && in_mem && !mem_ready
                   && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      fault_q   <= 1'b0;
      gpr_sel_q <= GPR_RD;
    end else begin
      state <= state_nx;
      if (in_mem && !mem_ready) wait_cnt <= wait_cnt + CW'(1);
      else                      wait_cnt <= '0;
      if (state_nx == S_TRAP) fault_q <= 1'b1;
      if (state == S_EXE_R)      gpr_sel_q <= GPR_RD;
      else if (state == S_EXE_I) gpr_sel_q <= GPR_RT;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (timeout) state_nx = S_TRAP;
                else if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          C_LOAD, C_STORE: state_nx = S_MEMADR;
          C_RTYPE:         state_nx = S_EXE_R;
          C_ITYPE:         state_nx = S_EXE_I;
          C_BRANCH:        state_nx = S_BRANCH;
          C_JUMP:          state_nx = S_JUMP;
          C_JREG:          state_nx = S_JREG;
          default:         state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: state_nx = (dec_cls == C_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (timeout) state_nx = S_TRAP;
                else if (mem_ready) state_nx = S_MEMWB;
      S_MEMWR:  if (timeout) state_nx = S_TRAP;
                else if (mem_ready) state_nx = S_FETCH;
      S_EXE_R, S_EXE_I: state_nx = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JREG: state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    EXTOp    = 1'b0;
    IorD     = 1'b0;
    alu_sel  = ALU_ADD;
    PCSource = PCS_PC4;
    ALUSrcA  = ASA_PC;
    ALUSrcB  = ASB_RT;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = ASB_4;
        end
      end
      S_DECODE: ALUSrcB = ASB_BR;
      S_MEMADR: begin
        ALUSrcA = ASA_RS;
        ALUSrcB = ASB_IMM;
        EXTOp   = 1'b1;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        GPRSel   = GPR_RT;
        WDSel    = WD_MEM;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = mem_ready;
      end
      S_EXE_R: begin
        ALUSrcA = dec_shift ? ASA_SHAMT : ASA_RS;
        ALUSrcB = ASB_RT;
        alu_sel = dec_alu;
      end
      S_EXE_I: begin
        ALUSrcA = ASA_RS;
        ALUSrcB = ASB_IMM;
        EXTOp   = dec_ext;
        alu_sel = dec_alu;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        GPRSel   = gpr_sel_q;
      end
      S_BRANCH: begin
        ALUSrcA  = ASA_RS;
        alu_sel  = ALU_SUB;
        PCSource = PCS_BR;
        PCWrite  = dec_bne ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSource = PCS_JMP;
        PCWrite  = 1'b1;
        if (dec_link) begin
          RegWrite = 1'b1;
          GPRSel   = GPR_RA;
          WDSel    = WD_PC;
        end
      end
      S_JREG: begin
        ALUSrcA  = ASA_RS;
        PCSource = PCS_REG;
        PCWrite  = 1'b1;
        if (dec_link) begin
          RegWrite = 1'b1;
          WDSel    = WD_PC;
        end
      end
      default: ;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign ALUOp     = ALUOP_W'(alu_sel);
  assign fault     = fault_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs: a per-instruction trace model builds the expected control
// word for every cycle, a negedge compare process checks it, plus literal spot checks.
module tb_mc_ctrl_hs;
  import mc_ctrl_pkg::*;

  localparam int TO = 16;
  localparam int W  = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = 6'h0, Funct = 6'h0;
  logic       Zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EXTOp, IorD, fault;
  logic [3:0] ALUOp, state_dbg;
  logic [1:0] PCSource, ALUSrcA, ALUSrcB, GPRSel, WDSel;

  mc_ctrl_hs #(.ALUOP_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .RegWrite(RegWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .EXTOp(EXTOp), .IorD(IorD), .ALUOp(ALUOp), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .GPRSel(GPRSel), .WDSel(WDSel),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int total = 0, bad = 0, cyc = 0;
  int rw_cnt = 0, mw_cnt = 0, req_cnt = 0;

  always @(negedge clk) begin : compare
    logic [W-1:0] e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state_dbg, mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EXTOp, IorD,
           ALUOp, PCSource, ALUSrcA, ALUSrcB, GPRSel, WDSel, fault};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL trace cyc=%0d got=%h expected=%h (state got=%0d exp=%0d)",
                 cyc, a, e, a[W-1 -: 4], e[W-1 -: 4]);
      end
      rw_cnt  += int'(RegWrite);
      mw_cnt  += int'(MemWrite);
      req_cnt += int'(mem_req);
    end
  end

  function automatic logic [W-1:0] cw(
    input logic [3:0] st, input logic req, rw, mw, pw, iw, ext, iord,
    input logic [3:0] aop, input logic [1:0] pcs, asa, asb, gsel, wds, input logic flt);
    return {st, req, rw, mw, pw, iw, ext, iord, aop, pcs, asa, asb, gsel, wds, flt};
  endfunction

  function automatic logic [W-1:0] w_trap();
    return cw(S_TRAP, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
  endfunction

  function automatic logic [W-1:0] w_mem(input logic [3:0] st, input logic iord, mw);
    return cw(st, 1, 0, mw, 0, 0, 0, iord, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
  endfunction

  task automatic step(input logic rdy, input logic [W-1:0] e);
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(0, cw(S_FETCH, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    rst = 1'b0;
    chk("reset_state", int'(state_dbg), 0);
    chk("reset_fault", int'(fault), 0);
  endtask

  // fw/dw: cycles mem_ready stays low before it rises, for the fetch and data access.
  task automatic run_instr(input logic [5:0] op, fn, input logic z, input int fw, dw);
    logic [3:0] aop;
    logic       sh, ok, lnk, pw;
    Op = op; Funct = fn; Zero = z;
    rw_cnt = 0; mw_cnt = 0; req_cnt = 0;
    for (int i = 0; i < fw && i < TO; i++) step(0, w_mem(S_FETCH, 0, 0));
    if (fw >= TO) begin step(0, w_trap()); return; end
    step(1, cw(S_FETCH, 1, 0, 0, 1, 1, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0));
    step(1, cw(S_DECODE, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 1'b0));
    case (op)
      6'h23, 6'h2B: begin
        step(1, cw(S_MEMADR, 0, 0, 0, 0, 0, 1, 0, ALU_ADD, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0));
        for (int i = 0; i < dw && i < TO; i++)
          step(0, w_mem(op == 6'h23 ? S_MEMRD : S_MEMWR, 1, 0));
        if (dw >= TO) begin step(0, w_trap()); return; end
        if (op == 6'h23) begin
          step(1, w_mem(S_MEMRD, 1, 0));
          step(1, cw(S_MEMWB, 0, 1, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0));
        end else begin
          step(1, w_mem(S_MEMWR, 1, 1));
        end
      end
      6'h00: begin
        ok = 1'b1; sh = 1'b0; aop = ALU_ADD;
        case (fn)
          6'h20, 6'h21: aop = ALU_ADD;
          6'h22, 6'h23: aop = ALU_SUB;
          6'h24:        aop = ALU_AND;
          6'h25:        aop = ALU_OR;
          6'h2A:        aop = ALU_SLT;
          6'h00:        begin aop = ALU_SLL; sh = 1'b1; end
          6'h02:        begin aop = ALU_SRL; sh = 1'b1; end
          default:      ok = 1'b0;
        endcase
        if (fn == 6'h08 || fn == 6'h09) begin
          lnk = (fn == 6'h09);
          step(1, cw(S_JREG, 0, lnk, 0, 1, 0, 0, 0, ALU_ADD, 2'd3, 2'd1, 2'd0, 2'd0,
                     lnk ? 2'd2 : 2'd0, 1'b0));
        end else if (!ok) begin
          step(1, w_trap());
        end else begin
          step(1, cw(S_EXE_R, 0, 0, 0, 0, 0, 0, 0, aop, 2'd0, sh ? 2'd2 : 2'd1, 2'd0,
                     2'd0, 2'd0, 1'b0));
          step(1, cw(S_ALUWB, 0, 1, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
        end
      end
      6'h08, 6'h0D, 6'h0F: begin
        aop = (op == 6'h08) ? ALU_ADD : (op == 6'h0D) ? ALU_OR : ALU_LUI;
        step(1, cw(S_EXE_I, 0, 0, 0, 0, 0, op == 6'h08, 0, aop, 2'd0, 2'd1, 2'd2,
                   2'd0, 2'd0, 1'b0));
        step(1, cw(S_ALUWB, 0, 1, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0));
      end
      6'h04, 6'h05: begin
        pw = (op == 6'h04) ? z : !z;
        step(1, cw(S_BRANCH, 0, 0, 0, pw, 0, 0, 0, ALU_SUB, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0));
      end
      6'h02, 6'h03: begin
        lnk = (op == 6'h03);
        step(1, cw(S_JUMP, 0, lnk, 0, 1, 0, 0, 0, ALU_ADD, 2'd2, 2'd0, 2'd0,
                   lnk ? 2'd2 : 2'd0, lnk ? 2'd2 : 2'd0, 1'b0));
      end
      default: step(1, w_trap());
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    run_instr(6'h00, 6'h21, 0, 0, 0);
    chk("addu_regwrite_pulses", rw_cnt, 1);
    chk("addu_back_in_fetch", int'(state_dbg), 0);
    run_instr(6'h00, 6'h23, 0, 2, 0);
    run_instr(6'h00, 6'h00, 0, 0, 0);
    run_instr(6'h00, 6'h02, 0, 1, 0);
    run_instr(6'h00, 6'h2A, 0, 0, 0);
    run_instr(6'h00, 6'h25, 0, 0, 0);

    run_instr(6'h23, 6'h00, 0, 0, 3);
    chk("lw_regwrite_pulses", rw_cnt, 1);
    chk("lw_mem_req_cycles", req_cnt, 5);
    chk("lw_fault", int'(fault), 0);
    run_instr(6'h2B, 6'h00, 0, 0, 2);
    chk("sw_memwrite_pulses", mw_cnt, 1);
    chk("sw_mem_req_cycles", req_cnt, 4);
    run_instr(6'h2B, 6'h00, 0, 3, TO - 1);
    chk("sw_edge_memwrite", mw_cnt, 1);
    chk("sw_edge_fault", int'(fault), 0);

    run_instr(6'h04, 6'h00, 1, 0, 0);
    run_instr(6'h05, 6'h00, 1, 0, 0);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0, 0);
    run_instr(6'h08, 6'h00, 0, 0, 0);
    run_instr(6'h0D, 6'h00, 0, 0, 0);
    run_instr(6'h0F, 6'h00, 0, 0, 0);
    run_instr(6'h02, 6'h00, 0, 0, 0);
    run_instr(6'h03, 6'h00, 0, 0, 0);
    chk("jal_regwrite_pulses", rw_cnt, 1);
    run_instr(6'h00, 6'h08, 0, 0, 0);
    run_instr(6'h00, 6'h09, 0, 0, 0);

    // Abandon a load part-way through the data wait.
    Op = 6'h23; Funct = 6'h00;
    step(1, cw(S_FETCH, 1, 0, 0, 1, 1, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0));
    step(0, cw(S_DECODE, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 1'b0));
    step(0, cw(S_MEMADR, 0, 0, 0, 0, 0, 1, 0, ALU_ADD, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0));
    step(0, w_mem(S_MEMRD, 1, 0));
    step(0, w_mem(S_MEMRD, 1, 0));
    do_reset();
    run_instr(6'h00, 6'h24, 0, 0, 0);

    run_instr(6'h00, 6'h21, 0, 40, 0);
    step(1, w_trap());
    step(1, w_trap());
    chk("fetch_timeout_req_cycles", req_cnt, TO);
    chk("fetch_timeout_fault", int'(fault), 1);
    chk("fetch_timeout_state", int'(state_dbg), int'(S_TRAP));
    do_reset();

    run_instr(6'h3F, 6'h00, 0, 0, 0);
    step(1, w_trap());
    chk("illegal_op_fault", int'(fault), 1);
    do_reset();
    run_instr(6'h00, 6'h3F, 0, 0, 0);
    do_reset();
    run_instr(6'h23, 6'h00, 0, 0, 30);
    chk("lw_timeout_fault", int'(fault), 1);
    do_reset();
    run_instr(6'h00, 6'h21, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
